// File: rtl/regfile_writeback_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_writeback_queue_if
// Description : Bundles the signals of the register-file writeback queue.
//               These are the ALU and load result handshakes, the drain port
//               to the register file (we3/a3/wd3), the forwarding lookup,
//               and the occupancy status.
//               slave  : the queue side (regfile_writeback_queue)
//               master : the pipeline / register-file side
// Revision    : 1.0 - initial release
// ============================================================================
interface regfile_writeback_queue_if #(
    parameter int DEPTH = 4
);
    localparam int c_CW = $clog2(DEPTH) + 1;

    logic              alu_valid;
    logic              alu_ready;
    logic [4:0]        alu_addr;
    logic [31:0]       alu_data;
    logic              mem_valid;
    logic              mem_ready;
    logic [4:0]        mem_addr;
    logic [31:0]       mem_data;
    logic              wb_busy;
    logic              we3;
    logic [4:0]        a3;
    logic [31:0]       wd3;
    logic [4:0]        q_addr;
    logic              q_hit;
    logic [31:0]       q_data;
    logic [c_CW-1:0]   count;
    logic              full;
    logic              empty;

    modport slave (
        input  alu_valid, alu_addr, alu_data,
        input  mem_valid, mem_addr, mem_data,
        input  wb_busy, q_addr,
        output alu_ready, mem_ready,
        output we3, a3, wd3,
        output q_hit, q_data,
        output count, full, empty
    );

    modport master (
        output alu_valid, alu_addr, alu_data,
        output mem_valid, mem_addr, mem_data,
        output wb_busy, q_addr,
        input  alu_ready, mem_ready,
        input  we3, a3, wd3,
        input  q_hit, q_data,
        input  count, full, empty
    );
endinterface
`default_nettype wire

// File: rtl/regfile_writeback_queue.sv
`default_nettype none
// ============================================================================
// Module      : regfile_writeback_queue
// Description : A small circular FIFO that buffers late ALU and load results.
//               Whenever the pipeline's own writeback slot is idle, it drains
//               the results one per cycle into the single write port of the
//               register file.
//   Ports     : clk    - clock, all state updates on posedge
//               reset  - synchronous, active-high
//               bus    - regfile_writeback_queue_if.slave. It carries the
//                        ALU and load handshakes, the we3/a3/wd3 drain port,
//                        the q_addr/q_hit/q_data forwarding lookup, and the
//                        count/full/empty status.
//   Config    : Define WBQ_BYPASS_EN to build the forwarding lookup.
//               Otherwise q_hit and q_data are tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_writeback_queue #(
    parameter int DEPTH = 4
) (
    input  wire logic                       clk,
    input  wire logic                       reset,
    regfile_writeback_queue_if.slave        bus
);
    localparam int c_PW = $clog2(DEPTH);
    localparam int c_CW = c_PW + 1;

    // Queue storage; the payload needs no reset because occupancy is
    // tracked solely by the pointers and count.
    logic [4:0]      r_addr [DEPTH];
    logic [31:0]     r_data [DEPTH];
    logic [c_PW-1:0] r_head;
    logic [c_PW-1:0] r_tail;
    logic [c_CW-1:0] r_count;

    logic            w_full;
    logic            w_empty;
    logic            w_mem_fire;
    logic            w_alu_fire;
    logic            w_push;
    logic            w_pop;
    logic [4:0]      w_push_addr;
    logic [31:0]     w_push_data;

    assign w_full  = (r_count == c_CW'(DEPTH));
    assign w_empty = (r_count == '0);

    // Readiness depends only on the registered count. A slot that is freed
    // by a drain in this cycle shows up as ready in the next cycle, which
    // keeps we3 out of the ready path.
    assign bus.mem_ready = !reset && !w_full;
    assign bus.alu_ready = !reset && !w_full && !bus.mem_valid;

    assign w_mem_fire  = bus.mem_valid && bus.mem_ready;
    assign w_alu_fire  = bus.alu_valid && bus.alu_ready;
    assign w_push_addr = w_mem_fire ? bus.mem_addr : bus.alu_addr;
    assign w_push_data = w_mem_fire ? bus.mem_data : bus.alu_data;

    // Writes to r0 complete the handshake, but they are dropped here.
    assign w_push = (w_mem_fire || w_alu_fire) && (w_push_addr != 5'd0);

    assign w_pop   = !reset && !w_empty && !bus.wb_busy;
    assign bus.we3 = w_pop;
    assign bus.a3  = (reset || w_empty) ? 5'd0  : r_addr[r_head];
    assign bus.wd3 = (reset || w_empty) ? 32'd0 : r_data[r_head];

    assign bus.count = r_count;
    assign bus.full  = w_full;
    assign bus.empty = w_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_tail] <= w_push_addr;
            r_data[r_tail] <= w_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + c_PW'(1);
            end
            if (w_pop) begin
                r_head <= r_head + c_PW'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef WBQ_BYPASS_EN
    logic            w_hit;
    logic [31:0]     w_fwd;
    logic [c_PW-1:0] w_idx;

    // The scan runs from oldest to youngest, so the last match wins and
    // the youngest pending write is forwarded. The head is still eligible
    // while it drains. The entry being pushed in this cycle is not yet
    // stored, so it cannot match.
    always_comb begin
        w_hit = 1'b0;
        w_fwd = 32'd0;
        w_idx = r_head;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = r_head + c_PW'(i);
            if ((c_CW'(i) < r_count) && (r_addr[w_idx] == bus.q_addr)) begin
                w_hit = 1'b1;
                w_fwd = r_data[w_idx];
            end
        end
        if (reset || (bus.q_addr == 5'd0)) begin
            w_hit = 1'b0;
            w_fwd = 32'd0;
        end
    end

    assign bus.q_hit  = w_hit;
    assign bus.q_data = w_fwd;
`else
    logic w_unused_q_addr;

    assign w_unused_q_addr = ^bus.q_addr;
    assign bus.q_hit       = 1'b0;
    assign bus.q_data      = 32'd0;
`endif

endmodule
`default_nettype wire

// File: doc/regfile_writeback_queue.md
# regfile_writeback_queue

Write-side initiator for the 32x32 register file. Buffers late register results from the ALU and load paths in a small FIFO and drains them, one per cycle, into the register file's single write port (we3/a3/wd3) whenever the pipeline's own writeback slot is idle. An optional lookup port lets the operand-read stage forward values that are still pending in the queue.

## Interface
- DEPTH, 4, queue entries; a power of two, at least 2
- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- alu_valid  in  1  ALU result offered
- alu_ready  out  1  ALU result accepted this cycle when alu_valid is also high
- alu_addr  in  5  destination register
- alu_data  in  32  result value
- mem_valid  in  1  load result offered
- mem_ready  out  1  load result accepted this cycle when mem_valid is also high
- mem_addr  in  5  destination register
- mem_data  in  32  load value
- wb_busy  in  1  pipeline is using the register-file write port this cycle; blocks draining
- we3  out  1  register-file write enable
- a3  out  5  register-file write address
- wd3  out  32  register-file write data
- q_addr  in  5  forwarding lookup address
- q_hit  out  1  a pending entry matches q_addr
- q_data  out  32  data of the youngest matching entry
- count  out  log2(DEPTH)+1  number of occupied entries
- full  out  1  count == DEPTH
- empty  out  1  count == 0

## Operation
- Circular FIFO of {addr[4:0], data[31:0]}, with head and tail pointers of log2(DEPTH) bits that wrap modulo DEPTH.
- Enqueue: at most one per cycle. mem has priority over alu.
  - mem_ready = !reset && !full
  - alu_ready = !reset && !full && !mem_valid
- Register 0: a handshake that completes with addr == 0 is accepted but not stored. count is unchanged.
- Drain:
  - we3 = !empty && !wb_busy, with a3/wd3 taken from the head entry.
  - When we3 is high, head advances at the posedge. The register file writes at the same edge.
  - When empty, a3 = 0 and wd3 = 0.
- Simultaneous enqueue and drain: count is unchanged and both pointers advance.
- Readiness is computed from the current count only. When full and draining in the same cycle, ready stays 0; the freed slot becomes visible the next cycle.
- Duplicate destinations are allowed. Entries drain in arrival order, so the younger write lands last.
- Forwarding (with WBQ_BYPASS_EN):
  - q_hit = 1 when some occupied entry has addr == q_addr and q_addr != 0.
  - q_data is the data of the youngest such entry (closest to tail). Otherwise q_data = 0.
  - The head entry being drained this cycle is still eligible.
  - The entry being enqueued this cycle is not visible.

## Timing
- Reset, while reset is high and at the first edge after it:
  - count = 0, head = tail = 0, empty = 1, full = 0
  - we3 = 0, a3 = 0, wd3 = 0
  - alu_ready = mem_ready = 0, q_hit = 0, q_data = 0
  - Reset in the middle of a drain discards all entries with no further writes.
- Latency: an entry accepted at edge N drives we3 during cycle N+1 if the queue was empty and wb_busy = 0. It is written into the register file at edge N+1.
- Throughput: one drain per non-busy cycle and one enqueue per cycle.
- All outputs are combinational from registered state and the current inputs. There are no combinational paths from we3 back into the ready signals.

## Configuration
- WBQ_BYPASS_EN defined: the forwarding logic is compiled in and q_hit/q_data behave as described under Operation.
- WBQ_BYPASS_EN undefined: no comparators are built, q_hit = 0 and q_data = 0 constantly, and q_addr is ignored. All other behaviour is identical.

## Test plan
- Reset, then alu_valid with addr 5 and data 0xDEADBEEF, wb_busy = 0 → alu_ready = 1. Next cycle we3 = 1, a3 = 5, wd3 = 0xDEADBEEF, and the register file holds 0xDEADBEEF in r5 after that edge. empty = 1 afterwards.
- Hold wb_busy = 1 and offer 5 distinct entries with DEPTH = 4 → 4 accepted, full = 1, ready = 0 on the 5th. Release wb_busy → the 4 entries drain in order over 4 cycles with we3 high continuously.
- Same cycle: mem_valid with addr 3 and data 0x11, alu_valid with addr 4 and data 0x22 → mem accepted, alu_ready = 0. The ALU entry is accepted the next cycle, and the drain order is r3 then r4.
- Enqueue addr 0 with data 0xFFFFFFFF → the handshake completes, count stays 0, and we3 never asserts. q_addr = 0 gives q_hit = 0.
- WBQ_BYPASS_EN with wb_busy = 1: enqueue r7 = 0x1, then r7 = 0x2 → q_addr = 7 gives q_hit = 1 and q_data = 0x2. Build without the macro → q_hit = 0.
- Fill to 3 entries, assert reset for one cycle mid-drain → count = 0, we3 = 0 the following cycle, and there are no further register-file writes.
